// File: rtl/riscv_lsu_pkg.sv
// Shared load/store size codes and size-decoding helpers for the LSU and decoder.
package riscv_lsu_pkg;

   localparam logic [2:0] LDST_B  = 3'd0;
   localparam logic [2:0] LDST_H  = 3'd1;
   localparam logic [2:0] LDST_W  = 3'd2;
   localparam logic [2:0] LDST_BU = 3'd4;
   localparam logic [2:0] LDST_HU = 3'd5;

   typedef enum logic [1:0] {
      ACC_B = 2'd0,
      ACC_H = 2'd1,
      ACC_W = 2'd2
   } acc_width_t;

   // Unused codes 3, 6 and 7 fall through to a full-word access.
   function automatic acc_width_t size_width(input logic [2:0] size);
      size_width = ACC_W;
      case (size)
         LDST_B, LDST_BU: size_width = ACC_B;
         LDST_H, LDST_HU: size_width = ACC_H;
         default:         size_width = ACC_W;
      endcase
   endfunction

   function automatic logic size_unsigned(input logic [2:0] size);
      size_unsigned = (size == LDST_BU) || (size == LDST_HU);
   endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Store-side byte-enable/lane replication and load-side lane extraction with
// sign or zero extension. Purely combinational.
module riscv_lsu_align
   import riscv_lsu_pkg::*;
(
   input  logic [2:0]  st_size,
   input  logic [1:0]  st_lane,
   input  logic [31:0] st_data,
   output logic [3:0]  be,
   output logic [31:0] wdata,
   input  logic [2:0]  ld_size,
   input  logic [1:0]  ld_lane,
   input  logic [31:0] rdata,
   output logic [31:0] ld_data
);

   logic [31:0] byte_shift;
   logic [31:0] half_shift;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic        ld_unsigned;

   always_comb begin
      be    = 4'b0000;
      wdata = 32'h0;
      case (size_width(st_size))
         ACC_B: begin
            be    = 4'b0001 << st_lane;
            wdata = {4{st_data[7:0]}};
         end
         ACC_H: begin
            be    = 4'b0011 << {st_lane[1], 1'b0};
            wdata = {2{st_data[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wdata = st_data;
         end
      endcase
   end

   assign byte_shift  = rdata >> {ld_lane, 3'b000};
   assign half_shift  = rdata >> {ld_lane[1], 4'b0000};
   assign byte_sel    = byte_shift[7:0];
   assign half_sel    = half_shift[15:0];
   assign ld_unsigned = size_unsigned(ld_size);

   always_comb begin
      ld_data = rdata;
      case (size_width(ld_size))
         ACC_B:   ld_data = ld_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         ACC_H:   ld_data = ld_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
         default: ld_data = rdata;
      endcase
   end

endmodule

// File: rtl/riscv_lsu.sv
// Load-store unit: req/gnt/rvalid bus master that stalls the core while busy.
// Optional misaligned-access trap enabled with `define RISCV_LSU_MISALIGN_EN.
module riscv_lsu
   import riscv_lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        lsu_req_i,
   input  logic        lsu_we_i,
   input  logic [2:0]  lsu_size_i,
   input  logic [31:0] lsu_addr_i,
   input  logic [31:0] lsu_data_i,
   output logic [31:0] lsu_data_o,
   output logic        lsu_stall_req_o,
   output logic        lsu_bus_err_o,
`ifdef RISCV_LSU_MISALIGN_EN
   output logic        lsu_misalign_o,
`endif
   output logic        data_req_o,
   output logic        data_we_o,
   output logic [3:0]  data_be_o,
   output logic [31:0] data_addr_o,
   output logic [31:0] data_wdata_o,
   input  logic        data_gnt_i,
   input  logic        data_rvalid_i,
   input  logic [31:0] data_rdata_i
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RSP  = 2'd2
   } state_t;

   state_t      state, state_next;
   logic        we_q;
   logic [2:0]  size_q;
   logic [1:0]  lane_q;
   logic        req_q;
   logic [3:0]  be_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic [31:0] wd_cnt;
   logic [3:0]  be_new;
   logic [31:0] wdata_new;
   logic [31:0] ld_data;
   logic        timeout;
   logic        start;
   logic        done;
   logic        misalign;

   riscv_lsu_align u_align (
      .st_size (lsu_size_i),
      .st_lane (lsu_addr_i[1:0]),
      .st_data (lsu_data_i),
      .be      (be_new),
      .wdata   (wdata_new),
      .ld_size (size_q),
      .ld_lane (lane_q),
      .rdata   (data_rdata_i),
      .ld_data (ld_data)
   );

`ifdef RISCV_LSU_MISALIGN_EN
   logic addr_bad;

   always_comb begin
      addr_bad = 1'b0;
      case (size_width(lsu_size_i))
         ACC_H:   addr_bad = lsu_addr_i[0];
         ACC_W:   addr_bad = |lsu_addr_i[1:0];
         default: addr_bad = 1'b0;
      endcase
   end

   assign misalign       = (state == IDLE) && lsu_req_i && addr_bad;
   assign lsu_misalign_o = misalign;
`else
   assign misalign = 1'b0;
`endif

   // Counter value equals cycles already spent busy; abort on the last allowed one.
   assign timeout = (TIMEOUT_CYCLES != 0) && (state != IDLE) &&
                    (wd_cnt == TIMEOUT_CYCLES - 32'd1);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      start      = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (lsu_req_i && !misalign) begin
               state_next = REQ;
               start      = 1'b1;
            end
         end
         REQ: begin
            if (timeout)         state_next = IDLE;
            else if (data_gnt_i) state_next = RSP;
         end
         RSP: begin
            if (timeout) begin
               state_next = IDLE;
            end else if (data_rvalid_i) begin
               state_next = IDLE;
               done       = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         we_q    <= 1'b0;
         size_q  <= 3'd0;
         lane_q  <= 2'd0;
         req_q   <= 1'b0;
         be_q    <= 4'b0000;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
         wd_cnt  <= 32'h0;
      end else begin
         if (start) begin
            we_q    <= lsu_we_i;
            size_q  <= lsu_size_i;
            lane_q  <= lsu_addr_i[1:0];
            addr_q  <= {lsu_addr_i[31:2], 2'b00};
            be_q    <= be_new;
            wdata_q <= wdata_new;
            req_q   <= 1'b1;
         end else if ((state == REQ) && (data_gnt_i || timeout)) begin
            req_q <= 1'b0;
         end
         if (done && !we_q) rdata_q <= ld_data;
         if ((state == IDLE) || timeout) wd_cnt <= 32'h0;
         else                            wd_cnt <= wd_cnt + 32'd1;
      end
   end

   assign data_req_o      = req_q;
   assign data_we_o       = we_q;
   assign data_be_o       = be_q;
   assign data_addr_o     = addr_q;
   assign data_wdata_o    = wdata_q;
   assign lsu_bus_err_o   = timeout;
   assign lsu_data_o      = done ? ld_data : rdata_q;
   assign lsu_stall_req_o = lsu_req_i && !done && !timeout && !misalign;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: bus encoding, load extension, stall timing,
// reset, watchdog abort (second instance) and the optional misalign trap.
module tb_riscv_lsu;
   import riscv_lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          n_cmp = 0;
   int          n_err = 0;

   logic        lsu_req = 1'b0, lsu_we = 1'b0;
   logic [2:0]  lsu_size = 3'd0;
   logic [31:0] lsu_addr = 32'h0, lsu_wd = 32'h0;
   logic        gnt = 1'b0, rvalid = 1'b0;
   logic [31:0] rdata = 32'h0;
   logic [31:0] lsu_data, daddr, dwdata;
   logic        stall, bus_err, dreq, dwe;
   logic [3:0]  dbe;

   logic        w_req = 1'b0;
   logic [31:0] w_addr = 32'h0;
   logic        w_gnt = 1'b0, w_rvalid = 1'b0;
   logic [31:0] w_rdata = 32'h0;
   logic [31:0] w_lsu_data, w_daddr, w_dwdata;
   logic        w_stall, w_bus_err, w_dreq, w_dwe;
   logic [3:0]  w_dbe;
`ifdef RISCV_LSU_MISALIGN_EN
   logic        misal, w_misal;
`endif

   always #5 clk = ~clk;

   riscv_lsu #(.TIMEOUT_CYCLES(0)) u_dut (
      .clk_i(clk), .rst_i(rst),
      .lsu_req_i(lsu_req), .lsu_we_i(lsu_we), .lsu_size_i(lsu_size),
      .lsu_addr_i(lsu_addr), .lsu_data_i(lsu_wd),
      .lsu_data_o(lsu_data), .lsu_stall_req_o(stall), .lsu_bus_err_o(bus_err),
`ifdef RISCV_LSU_MISALIGN_EN
      .lsu_misalign_o(misal),
`endif
      .data_req_o(dreq), .data_we_o(dwe), .data_be_o(dbe),
      .data_addr_o(daddr), .data_wdata_o(dwdata),
      .data_gnt_i(gnt), .data_rvalid_i(rvalid), .data_rdata_i(rdata)
   );

   riscv_lsu #(.TIMEOUT_CYCLES(4)) u_wd (
      .clk_i(clk), .rst_i(rst),
      .lsu_req_i(w_req), .lsu_we_i(1'b0), .lsu_size_i(LDST_W),
      .lsu_addr_i(w_addr), .lsu_data_i(32'h0),
      .lsu_data_o(w_lsu_data), .lsu_stall_req_o(w_stall), .lsu_bus_err_o(w_bus_err),
`ifdef RISCV_LSU_MISALIGN_EN
      .lsu_misalign_o(w_misal),
`endif
      .data_req_o(w_dreq), .data_we_o(w_dwe), .data_be_o(w_dbe),
      .data_addr_o(w_daddr), .data_wdata_o(w_dwdata),
      .data_gnt_i(w_gnt), .data_rvalid_i(w_rvalid), .data_rdata_i(w_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Drives one transaction on u_dut and acts as the memory; returns observations.
   task automatic txn(input logic we, input logic [2:0] size, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] rd,
                      input int gdly, input int rdly,
                      output int stalls, output int reqs, output logic [31:0] ldv,
                      output logic [3:0] be_s, output logic [31:0] wdata_s);
      int   gcnt = 0;
      int   rcnt = 0;
      logic granted = 1'b0;
      logic done = 1'b0;
      stalls = 0; reqs = 0; ldv = 32'h0; be_s = 4'h0; wdata_s = 32'h0;
      lsu_req = 1'b1; lsu_we = we; lsu_size = size; lsu_addr = addr; lsu_wd = wd;
      gnt = 1'b0; rvalid = 1'b0;
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         @(negedge clk);
         if (stall) stalls++;
         if (dreq) begin
            if (reqs == 0) begin
               be_s = dbe;
               wdata_s = dwdata;
               chk("req_we", {31'h0, dwe}, {31'h0, we});
            end
            reqs++;
            chk("req_addr", daddr, {addr[31:2], 2'b00});
         end
         if (rvalid) begin
            done = 1'b1;
            ldv = lsu_data;
            chk("stall_done", {31'h0, stall}, 32'h0);
         end
         next_cycle();
         gnt = 1'b0; rvalid = 1'b0;
         if (!done) begin
            if (granted) begin
               if (rcnt == rdly) begin rvalid = 1'b1; rdata = rd; end
               rcnt++;
            end else if (dreq) begin
               if (gcnt == gdly) begin gnt = 1'b1; granted = 1'b1; end
               gcnt++;
            end
         end
      end
      if (!done) chk("txn_bound", 32'h0, 32'h1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time bound exceeded");
   end

   initial begin
      int          st, rq;
      logic [31:0] lv, ws;
      logic [3:0]  bs;

      // Reset state
      @(negedge clk);
      chk("rst_req", {31'h0, dreq}, 32'h0);
      chk("rst_we", {31'h0, dwe}, 32'h0);
      chk("rst_be", {28'h0, dbe}, 32'h0);
      chk("rst_addr", daddr, 32'h0);
      chk("rst_wdata", dwdata, 32'h0);
      chk("rst_err", {31'h0, bus_err}, 32'h0);
      chk("rst_data", lsu_data, 32'h0);
      chk("rst_stall", {31'h0, stall}, 32'h0);
      next_cycle();
      rst = 1'b0;
      next_cycle();

      // SW, immediate gnt/rvalid
      txn(1'b1, LDST_W, 32'h104, 32'hDEADBEEF, 32'h0, 0, 0, st, rq, lv, bs, ws);
      lsu_req = 1'b0;
      chk("sw_be", {28'h0, bs}, 32'h0000000F);
      chk("sw_wdata", ws, 32'hDEADBEEF);
      chk("sw_stalls", st, 2);
      chk("sw_reqs", rq, 1);

      // SB to lane 3
      txn(1'b1, LDST_B, 32'h203, 32'h000000A5, 32'h0, 0, 0, st, rq, lv, bs, ws);
      lsu_req = 1'b0;
      chk("sb_be", {28'h0, bs}, 32'h00000008);
      chk("sb_wdata", ws, 32'hA5A5A5A5);
      chk("sb_stalls", st, 2);

      // SH to upper half
      txn(1'b1, LDST_H, 32'h202, 32'h00001234, 32'h0, 0, 0, st, rq, lv, bs, ws);
      lsu_req = 1'b0;
      chk("sh_be", {28'h0, bs}, 32'h0000000C);
      chk("sh_wdata", ws, 32'h12341234);

      // Byte/half loads from lane 2
      txn(1'b0, LDST_B, 32'h302, 32'h0, 32'h11802233, 0, 0, st, rq, lv, bs, ws);
      lsu_req = 1'b0;
      chk("lb_bypass", lv, 32'hFFFFFF80);
      chk("lb_be", {28'h0, bs}, 32'h00000004);
      @(negedge clk);
      chk("lb_held", lsu_data, 32'hFFFFFF80);
      next_cycle();
      txn(1'b0, LDST_BU, 32'h302, 32'h0, 32'h11802233, 0, 0, st, rq, lv, bs, ws);
      lsu_req = 1'b0;
      chk("lbu_data", lv, 32'h00000080);
      txn(1'b0, LDST_HU, 32'h302, 32'h0, 32'h11802233, 0, 0, st, rq, lv, bs, ws);
      lsu_req = 1'b0;
      chk("lhu_data", lv, 32'h00001180);
      chk("lhu_be", {28'h0, bs}, 32'h0000000C);
      txn(1'b0, LDST_H, 32'h300, 32'h0, 32'h11808001, 0, 0, st, rq, lv, bs, ws);
      lsu_req = 1'b0;
      chk("lh_data", lv, 32'hFFFF8001);
      txn(1'b0, LDST_BU, 32'h301, 32'h0, 32'h11802233, 0, 0, st, rq, lv, bs, ws);
      lsu_req = 1'b0;
      chk("lbu1_data", lv, 32'h00000022);

      // LW with delayed gnt/rvalid, then back-to-back LW
      txn(1'b0, LDST_W, 32'h700, 32'h0, 32'hA5A50F0F, 3, 1, st, rq, lv, bs, ws);
      chk("lwd_reqs", rq, 4);
      chk("lwd_stalls", st, 6);
      chk("lwd_data", lv, 32'hA5A50F0F);
      txn(1'b0, LDST_W, 32'h704, 32'h0, 32'h01020304, 0, 0, st, rq, lv, bs, ws);
      lsu_req = 1'b0;
      chk("b2b_stalls", st, 2);
      chk("b2b_reqs", rq, 1);
      chk("b2b_data", lv, 32'h01020304);

      // lsu_req dropped mid-transaction
      lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = LDST_W; lsu_addr = 32'h400;
      @(negedge clk);
      next_cycle();
      lsu_req = 1'b0; gnt = 1'b1;
      @(negedge clk);
      chk("drop_req", {31'h0, dreq}, 32'h1);
      chk("drop_stall", {31'h0, stall}, 32'h0);
      next_cycle();
      gnt = 1'b0; rvalid = 1'b1; rdata = 32'hCAFEF00D;
      @(negedge clk);
      chk("drop_bypass", lsu_data, 32'hCAFEF00D);
      next_cycle();
      rvalid = 1'b0;
      @(negedge clk);
      chk("drop_held", lsu_data, 32'hCAFEF00D);
      chk("drop_idle", {31'h0, dreq}, 32'h0);
      next_cycle();

      // Watchdog: prime rdata_q, then a request that is never granted
      w_req = 1'b1; w_addr = 32'h600;
      @(negedge clk);
      next_cycle();
      w_gnt = 1'b1;
      @(negedge clk);
      chk("wd_req", {31'h0, w_dreq}, 32'h1);
      next_cycle();
      w_gnt = 1'b0; w_rvalid = 1'b1; w_rdata = 32'h12345678;
      @(negedge clk);
      chk("wd_prime", w_lsu_data, 32'h12345678);
      next_cycle();
      w_rvalid = 1'b0; w_addr = 32'h604;
      @(negedge clk);
      chk("wd_idle_stall", {31'h0, w_stall}, 32'h1);
      for (int k = 1; k <= 4; k++) begin
         next_cycle();
         if (k == 4) w_gnt = 1'b1;
         @(negedge clk);
         chk($sformatf("wd_err_%0d", k), {31'h0, w_bus_err}, (k == 4) ? 32'h1 : 32'h0);
         chk($sformatf("wd_stall_%0d", k), {31'h0, w_stall}, (k == 4) ? 32'h0 : 32'h1);
         chk($sformatf("wd_dreq_%0d", k), {31'h0, w_dreq}, 32'h1);
      end
      next_cycle();
      w_gnt = 1'b0; w_req = 1'b0;
      @(negedge clk);
      chk("wd_after_req", {31'h0, w_dreq}, 32'h0);
      chk("wd_after_err", {31'h0, w_bus_err}, 32'h0);
      chk("wd_rdata_kept", w_lsu_data, 32'h12345678);
      next_cycle();

      // Asynchronous reset while in RSP
      lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = LDST_W; lsu_addr = 32'h500;
      @(negedge clk);
      next_cycle();
      gnt = 1'b1;
      @(negedge clk);
      chk("rsp_pre_req", {31'h0, dreq}, 32'h1);
      next_cycle();
      gnt = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("arst_req", {31'h0, dreq}, 32'h0);
      chk("arst_stall_req", {31'h0, stall}, 32'h1);
      chk("arst_data", lsu_data, 32'h0);
      lsu_req = 1'b0;
      #1;
      chk("arst_stall_idle", {31'h0, stall}, 32'h0);
      next_cycle();
      rst = 1'b0;
      next_cycle();

`ifdef RISCV_LSU_MISALIGN_EN
      lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = LDST_W; lsu_addr = 32'h101;
      @(negedge clk);
      chk("mis_flag", {31'h0, misal}, 32'h1);
      chk("mis_stall", {31'h0, stall}, 32'h0);
      next_cycle();
      lsu_req = 1'b0;
      @(negedge clk);
      chk("mis_noreq", {31'h0, dreq}, 32'h0);
      chk("mis_data", lsu_data, 32'h0);
      next_cycle();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
Load-store unit directly downstream of the instruction decoder. It consumes the decoder's memory controls (request, write enable, size code) together with the ALU-computed address and rs2 store data. It runs the request/grant/response handshake with the data memory, generates byte enables and lane-replicated store data, and sign- or zero-extends load data. While a transaction is outstanding it stalls the single-cycle core.

Parameters:
TIMEOUT_CYCLES, 0, maximum cycles spent in REQ+RSP before abort; 0 disables the watchdog.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
lsu_req_i  in  1  memory request from decoder (mem_req)
lsu_we_i  in  1  1 = store, 0 = load (decoder mem_we)
lsu_size_i  in  3  0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU (decoder mem_size)
lsu_addr_i  in  32  byte address from ALU
lsu_data_i  in  32  store data (rs2)
lsu_data_o  out  32  load result to writeback mux
lsu_stall_req_o  out  1  stall core/PC while high
lsu_bus_err_o  out  1  one-cycle pulse on watchdog abort
data_req_o  out  1  memory request
data_we_o  out  1  memory write enable
data_be_o  out  4  byte enables
data_addr_o  out  32  word-aligned address {addr[31:2],2'b00}
data_wdata_o  out  32  lane-replicated store data
data_gnt_i  in  1  memory accepted request
data_rvalid_i  in  1  response valid (read data or write ack)
data_rdata_i  in  32  read data

Behaviour:
- Reset (asynchronous, any state): FSM goes to IDLE. data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o, lsu_bus_err_o are 0. Read-data register rdata_q is 0. The watchdog counter is 0.
- FSM states are IDLE, REQ, RSP.
  - IDLE: if lsu_req_i, latch we/size/addr, generate BE and wdata, then go to REQ.
  - REQ: data_req_o = 1. Bus outputs are registered and held stable until data_gnt_i. On gnt, go to RSP (data_req_o drops the next cycle).
  - RSP: wait for data_rvalid_i; on rvalid, go to IDLE. Writes also wait for rvalid as the acknowledgment.
- lsu_stall_req_o = lsu_req_i & ~(state==RSP & data_rvalid_i), combinational. The core holds its inputs stable while stalled.
- Minimum latency: 3 cycles (IDLE, REQ with gnt, RSP with rvalid), so the stall lasts 2 cycles. In the IDLE cycle after completion, a new lsu_req_i starts the next transaction immediately.
- Load data is extracted with lane = addr_q[1:0]:
  - B/BU: rdata[8*lane +: 8], sign- or zero-extended.
  - H/HU: rdata[16*addr_q[1] +: 16], sign- or zero-extended.
  - W: rdata unchanged.
- lsu_data_o = extracted value in the completion cycle (combinational bypass); otherwise rdata_q. rdata_q is updated on load completion only.
- Store encoding:
  - B: be = 4'b0001 << addr[1:0], wdata = {4{d[7:0]}}.
  - H: be = 4'b0011 << {addr[1],1'b0}, wdata = {2{d[15:0]}}.
  - W: be = 4'b1111, wdata = d.
  - Loads: be as for the same size (B/BU as B, H/HU as H).
  - Sizes 3, 6, 7 are treated as W.
- lsu_req_i dropping mid-transaction: the bus protocol still completes. rdata_q is still updated for loads, and the stall is low.
- Watchdog (TIMEOUT_CYCLES > 0): the counter increments each cycle in REQ or RSP and clears in IDLE. When it reaches TIMEOUT_CYCLES, the FSM returns to IDLE, data_req_o goes to 0, lsu_bus_err_o pulses for 1 cycle, the stall is released for that cycle, and rdata_q is unchanged. A gnt or rvalid arriving in the abort cycle is ignored.

Optional Feature:
RISCV_LSU_MISALIGN_EN.
- With the macro: adds port lsu_misalign_o (out, 1). A H/HU access with addr[0] = 1, or a W access with addr[1:0] != 0, issues no bus request. lsu_misalign_o pulses in the IDLE cycle, the stall is low in that cycle, the FSM stays in IDLE, and rdata_q is unchanged.
- Without the macro: there is no port. Low address bits are ignored for H (addr[0]) and W (addr[1:0]).

Decomposition:
- miriscv_defines gains LDST_B = 3'd0, LDST_H = 3'd1, LDST_W = 3'd2, LDST_BU = 3'd4, LDST_HU = 3'd5, shared with the decoder.
- FSM state encodings are local localparams.
- One combinational sub-module, riscv_lsu_align, does BE/wdata generation and load extraction/extension.

Test Plan:
- SW addr = 0x104, d = 0xDEADBEEF, gnt and rvalid immediate -> data_addr_o = 0x104, be = 1111, wdata = 0xDEADBEEF, stall high for exactly 2 cycles.
- SB addr = 0x203, d = 0x000000A5 -> be = 1000, wdata = 0xA5A5A5A5, data_addr_o = 0x200.
- LB addr = 0x302, rdata = 0x11802233 -> lsu_data_o = 0xFFFFFF80. LBU at the same address -> 0x00000080. LHU addr = 0x302 -> 0x00001180.
- LW with gnt delayed 3 cycles and rvalid 2 cycles after gnt -> data_req_o held with stable addr for 4 cycles, stall released exactly in the rvalid cycle, back-to-back second LW starts the next cycle.
- TIMEOUT_CYCLES = 4, gnt never asserted -> lsu_bus_err_o pulses on the 4th REQ cycle, FSM returns to IDLE, rdata_q retains its prior value.
- rst_i asserted while in RSP -> data_req_o = 0 and stall tracks only lsu_req_i from IDLE. With RISCV_LSU_MISALIGN_EN, LW addr = 0x101 -> lsu_misalign_o = 1, no data_req_o.
